// File: rtl/maze_path_solver_if.sv
`default_nettype none
// ============================================================================
//  Module   : maze_path_solver_if
//  Purpose  : Serial maze input and path-step output bundle for
//             maze_path_solver.
//  Signals  : in_valid  - maze bit strobe (DIM*DIM consecutive cycles)
//             in        - maze bit, 1 = open, 0 = wall
//             out_valid - path step or no-path report present
//             out       - direction code 0=right 1=down 2=left 3=up
//             no_path   - goal unreachable (one cycle, with out_valid)
//  Modports : master (maze source / path sink), slave (solver)
//  Revision : 1.0 - initial release
// ============================================================================
interface maze_path_solver_if;
    logic       in_valid;
    logic       in;
    logic       out_valid;
    logic [1:0] out;
    logic       no_path;

    modport master (
        output in_valid,
        output in,
        input  out_valid,
        input  out,
        input  no_path
    );

    modport slave (
        input  in_valid,
        input  in,
        output out_valid,
        output out,
        output no_path
    );
endinterface
`default_nettype wire

// File: rtl/maze_path_solver.sv
`default_nettype none
// ============================================================================
//  Module   : maze_path_solver
//  Purpose  : Loads a DIM x DIM binary maze serially (row-major, one bit per
//             cycle), floods a wavefront outward from the goal cell
//             (DIM-1,DIM-1) in parallel across all cells, then walks from
//             (0,0) following the recorded directions, emitting one 2-bit
//             direction code per cycle. Because each cell records a
//             neighbour that was reached exactly one wavefront earlier, the
//             emitted path is a shortest path. An unreachable goal produces a
//             single no_path report cycle instead.
//  Ports    : clk   - system clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - maze_path_solver_if.slave (in_valid, in, out_valid,
//                     out, no_path)
//  Params   : DIM   - maze side length (odd, 3..31)
//             CW    - input-bit counter width
//  Revision : 1.0 - initial release
// ============================================================================
module maze_path_solver #(
    parameter int DIM = 17,
    parameter int CW  = $clog2(DIM*DIM+1)
) (
    input  logic               clk,
    input  logic               rst_n,
    maze_path_solver_if.slave  bus
);

    localparam int C_CELLS = DIM * DIM;
    localparam int C_GOAL  = C_CELLS - 1;
    localparam int RW      = $clog2(DIM);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_FLOOD  = 3'd2;
    localparam logic [2:0] S_WALK   = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    localparam logic [1:0] C_RIGHT = 2'd0;
    localparam logic [1:0] C_DOWN  = 2'd1;
    localparam logic [1:0] C_LEFT  = 2'd2;
    localparam logic [1:0] C_UP    = 2'd3;

    logic [2:0]                 r_state;
    logic [CW-1:0]              r_cnt;
    logic [CW-1:0]              r_guard;
    logic                       r_first;
    logic [C_CELLS-1:0]         r_maze;
    logic [C_CELLS-1:0]         r_vis;
    logic [C_CELLS-1:0][1:0]    r_dir;
    logic [RW-1:0]              r_cur_r;
    logic [RW-1:0]              r_cur_c;

    logic [C_CELLS-1:0]         w_grow;
    logic [C_CELLS-1:0][1:0]    w_dir_nxt;
    logic [DIM+1:0][DIM+1:0]    w_pad;
    logic [CW-1:0]              w_cur_idx;
    logic [1:0]                 w_cur_dir;
    logic [RW-1:0]              w_nxt_r;
    logic [RW-1:0]              w_nxt_c;
    logic                       w_nxt_goal;

    // ------------------------------------------------------------------
    // Visited map surrounded by a ring of permanent walls, so every cell
    // sees four in-range neighbours and border cells can never point off
    // the grid.
    // ------------------------------------------------------------------
    for (genvar pr = 0; pr < DIM + 2; pr++) begin : g_pad_row
        for (genvar pc = 0; pc < DIM + 2; pc++) begin : g_pad_col
            if (pr >= 1 && pr <= DIM && pc >= 1 && pc <= DIM) begin : g_inner
                assign w_pad[pr][pc] = r_vis[(pr-1)*DIM + (pc-1)];
            end else begin : g_border
                assign w_pad[pr][pc] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cell wavefront step. A cell joins the front when it is open,
    // not yet visited, and any neighbour was visited in the previous
    // cycle. All such neighbours sit at the same distance from the goal,
    // so the fixed priority only breaks ties between equal-length routes.
    // ------------------------------------------------------------------
    for (genvar gr = 0; gr < DIM; gr++) begin : g_row
        for (genvar gc = 0; gc < DIM; gc++) begin : g_col
            localparam int IDX = gr * DIM + gc;
            logic w_vr;
            logic w_vd;
            logic w_vl;
            logic w_vu;

            assign w_vr = w_pad[gr+1][gc+2];
            assign w_vd = w_pad[gr+2][gc+1];
            assign w_vl = w_pad[gr+1][gc];
            assign w_vu = w_pad[gr][gc+1];

            assign w_grow[IDX] = r_maze[IDX] & ~r_vis[IDX] &
                                 (w_vr | w_vd | w_vl | w_vu);

            assign w_dir_nxt[IDX] = !w_grow[IDX] ? r_dir[IDX] :
                                    w_vr         ? C_RIGHT    :
                                    w_vd         ? C_DOWN     :
                                    w_vl         ? C_LEFT     : C_UP;
        end
    end

    // ------------------------------------------------------------------
    // Walk pointer: direction of the current cell and the cell it leads to.
    // ------------------------------------------------------------------
    assign w_cur_idx = CW'(r_cur_r) * CW'(DIM) + CW'(r_cur_c);
    assign w_cur_dir = r_dir[w_cur_idx];

    always_comb begin
        w_nxt_r = r_cur_r;
        w_nxt_c = r_cur_c;
        case (w_cur_dir)
            C_RIGHT: w_nxt_c = r_cur_c + RW'(1);
            C_DOWN:  w_nxt_r = r_cur_r + RW'(1);
            C_LEFT:  w_nxt_c = r_cur_c - RW'(1);
            default: w_nxt_r = r_cur_r - RW'(1);
        endcase
    end

    assign w_nxt_goal = (w_nxt_r == RW'(DIM-1)) && (w_nxt_c == RW'(DIM-1));

    // ------------------------------------------------------------------
    // Control FSM and storage.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_guard <= '0;
            r_first <= 1'b0;
            r_maze  <= '0;
            r_vis   <= '0;
            r_dir   <= '0;
            r_cur_r <= '0;
            r_cur_c <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_maze[0] <= bus.in;
                        r_cnt     <= CW'(1);
                        r_vis     <= '0;
                        r_dir     <= '0;
                        r_cur_r   <= '0;
                        r_cur_c   <= '0;
                        r_state   <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (bus.in_valid) begin
                        r_maze[r_cnt] <= bus.in;
                        r_cnt         <= r_cnt + CW'(1);
                        if (r_cnt == CW'(C_GOAL)) begin
                            r_first <= 1'b1;
                            r_guard <= '0;
                            r_state <= S_FLOOD;
                        end
                    end
                end

                S_FLOOD: begin
                    if (r_first) begin
                        // Seed the wavefront at the goal; a walled goal is
                        // unreachable by definition.
                        r_first <= 1'b0;
                        if (r_maze[C_GOAL]) begin
                            r_vis[C_GOAL] <= 1'b1;
                        end else begin
                            r_state <= S_REPORT;
                        end
                    end else begin
                        r_vis   <= r_vis | w_grow;
                        r_dir   <= w_dir_nxt;
                        r_guard <= r_guard + CW'(1);
                        if (w_grow[0]) begin
                            // Start reached this cycle: its direction is
                            // written at the same edge the walk begins.
                            r_cur_r <= '0;
                            r_cur_c <= '0;
                            r_state <= S_WALK;
                        end else if (w_grow == '0) begin
                            r_state <= S_REPORT;
                        end else if (r_guard == CW'(C_CELLS - 1)) begin
                            r_state <= S_REPORT;
                        end
                    end
                end

                S_WALK: begin
                    r_cur_r <= w_nxt_r;
                    r_cur_c <= w_nxt_c;
                    if (w_nxt_goal) begin
                        r_state <= S_IDLE;
                    end
                end

                S_REPORT: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs derive straight from state so an asynchronous reset silences
    // them immediately.
    assign bus.out_valid = (r_state == S_WALK) || (r_state == S_REPORT);
    assign bus.out       = (r_state == S_WALK) ? w_cur_dir : 2'd0;
    assign bus.no_path   = (r_state == S_REPORT);

endmodule
`default_nettype wire

// File: tb/tb_maze_path_solver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maze_path_solver
//  Purpose  : Self-checking bench for maze_path_solver at DIM=5 (table of
//             small mazes) and DIM=17 (two-route maze, reset during walk,
//             back-to-back mazes). Expected steps are queued when a maze is
//             sent and compared as the solver emits them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_maze_path_solver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst5_n;
    logic rst17_n;

    maze_path_solver_if if5();
    maze_path_solver_if if17();

    maze_path_solver #(.DIM(5)) u_dut5 (
        .clk   (clk),
        .rst_n (rst5_n),
        .bus   (if5)
    );

    maze_path_solver #(.DIM(17)) u_dut17 (
        .clk   (clk),
        .rst_n (rst17_n),
        .bus   (if17)
    );

    int checks = 0;
    int errors = 0;

    // {no_path, out} of each expected output cycle
    logic [2:0]   exp_q[$];
    logic [288:0] m17;

    typedef struct {
        string       name;
        logic [24:0] maze;
        int          len;
        logic [15:0] seq;   // step k in seq[2k+1:2k]
        bit          np;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] sample(input int dim);
        if (dim == 5) return {if5.out_valid, if5.no_path, if5.out};
        return {if17.out_valid, if17.no_path, if17.out};
    endfunction

    task automatic set17(input int r, input int c);
        m17[r*17 + c] = 1'b1;
    endtask

    task automatic push_run(input int count, input logic [1:0] dir);
        for (int i = 0; i < count; i++) exp_q.push_back({1'b0, dir});
    endtask

    // Called on a falling edge; returns on the falling edge after the last bit.
    task automatic send(input int dim, input logic [288:0] m);
        for (int i = 0; i < dim*dim; i++) begin
            if (dim == 5) begin if5.in_valid = 1'b1;  if5.in = m[i];  end
            else          begin if17.in_valid = 1'b1; if17.in = m[i]; end
            @(negedge clk);
        end
        if (dim == 5) begin if5.in_valid = 1'b0;  if5.in = 1'b0;  end
        else          begin if17.in_valid = 1'b0; if17.in = 1'b0; end
    endtask

    task automatic collect(input int dim, input int bound, input int exp_len,
                           input bit replay, input string tag);
        int k;
        int n;
        int r;
        int c;
        int open;
        logic [3:0] s;
        logic [2:0] e;
        k = 0;
        s = sample(dim);
        while (!s[3] && k < 3000) begin
            @(negedge clk);
            k++;
            s = sample(dim);
        end
        if (!s[3]) begin
            check({tag, " timeout"}, 0, 1);
            exp_q.delete();
            return;
        end
        checks++;
        if (k > bound) begin
            errors++;
            $display("FAIL %s latency actual=%0d required<=%0d", tag, k, bound);
        end
        n = 0;
        r = 0;
        c = 0;
        while (s[3] && n < 2000) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("%s step%0d", tag, n), int'(s[2:0]), int'(e));
            end
            if (replay) begin
                case (s[1:0])
                    2'd0:    c++;
                    2'd1:    r++;
                    2'd2:    c--;
                    default: r--;
                endcase
                open = (r >= 0 && r < 17 && c >= 0 && c < 17) ? int'(m17[r*17 + c]) : 0;
                check($sformatf("%s open%0d", tag, n), open, 1);
            end
            n++;
            @(negedge clk);
            s = sample(dim);
        end
        check({tag, " length"}, n, exp_len);
        check({tag, " idle_outputs"}, int'(s), 0);
        if (replay) check({tag, " endpos"}, r*17 + c, 288);
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int k;
        int ov_count;
        logic [3:0] s;
        vec_t v;

        vecs[0] = '{name:"open5",      maze:25'h1FFFFFF, len:8, seq:16'h5500, np:1'b0};
        vecs[1] = '{name:"lshape5",    maze:25'h1F08421, len:8, seq:16'h0055, np:1'b0};
        vecs[2] = '{name:"goalwall5",  maze:25'h0FFFFFF, len:0, seq:16'h0000, np:1'b1};
        vecs[3] = '{name:"startwall5", maze:25'h1FFFFFE, len:0, seq:16'h0000, np:1'b1};
        vecs[4] = '{name:"rightwall5", maze:25'h1FFFFFD, len:8, seq:16'h5401, np:1'b0};
        vecs[5] = '{name:"isolated5",  maze:25'h177FFFF, len:0, seq:16'h0000, np:1'b1};

        rst5_n  = 1'b0;
        rst17_n = 1'b0;
        if5.in_valid  = 1'b0; if5.in  = 1'b0;
        if17.in_valid = 1'b0; if17.in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset5_outputs", int'(sample(5)), 0);
        check("reset17_outputs", int'(sample(17)), 0);
        rst5_n  = 1'b1;
        rst17_n = 1'b1;
        @(negedge clk);

        // ---------------- DIM=5 table ----------------
        for (int t = 0; t < 6; t++) begin
            v = vecs[t];
            if (v.np) exp_q.push_back(3'b100);
            else for (int j = 0; j < v.len; j++) exp_q.push_back({1'b0, v.seq[2*j +: 2]});
            send(5, 289'(v.maze));
            collect(5, $countones(v.maze) + 2, v.np ? 1 : v.len, 1'b0, v.name);
        end

        // ---------------- DIM=17 two routes (32 and 48) ----------------
        m17 = '0;
        for (int c = 0; c < 17; c++) set17(0, c);
        for (int r = 0; r < 17; r++) set17(r, 16);
        for (int r = 0; r < 17; r++) set17(r, 0);
        for (int c = 0; c <= 4; c++) set17(16, c);
        for (int r = 8; r < 17; r++) set17(r, 4);
        for (int c = 4; c <= 8; c++) set17(8, c);
        for (int r = 8; r < 17; r++) set17(r, 8);
        for (int c = 8; c < 17; c++) set17(16, c);

        push_run(16, 2'd0);
        push_run(16, 2'd1);
        send(17, m17);
        collect(17, $countones(m17) + 2, 32, 1'b1, "routes17");

        // ---------------- reset during walk step 5 ----------------
        send(17, m17);
        k = 0;
        s = sample(17);
        while (!s[3] && k < 3000) begin
            @(negedge clk);
            k++;
            s = sample(17);
        end
        check("rst_walk_started", int'(s[3]), 1);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("rst_walk step%0d", j), int'(s), 4'b1000);
            @(negedge clk);
            s = sample(17);
        end
        check("rst_walk step5", int'(s), 4'b1000);
        #2;
        rst17_n = 1'b0;
        #1;
        check("rst_async_outputs", int'(sample(17)), 0);
        @(negedge clk);
        rst17_n = 1'b1;
        ov_count = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (if17.out_valid) ov_count++;
        end
        check("rst_no_further_steps", ov_count, 0);

        push_run(16, 2'd0);
        push_run(16, 2'd1);
        send(17, m17);
        collect(17, $countones(m17) + 2, 32, 1'b1, "after_rst17");

        // ---------------- back-to-back, zero gap ----------------
        push_run(16, 2'd0);
        push_run(16, 2'd1);
        send(17, m17);
        collect(17, $countones(m17) + 2, 32, 1'b1, "b2b_first");

        m17 = '0;
        for (int r = 0; r < 17; r++) set17(r, 0);
        for (int c = 0; c < 17; c++) set17(16, c);
        push_run(16, 2'd1);
        push_run(16, 2'd0);
        send(17, m17);
        collect(17, $countones(m17) + 2, 32, 1'b1, "b2b_second");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
